// File: rtl/modarith_pkg.sv
// Shared definitions for the modular-arithmetic blocks: FSM state type for
// the sequential multiplier and the bit-index width helper.
package modarith_pkg;

    typedef enum logic [1:0] {
        MODMUL_IDLE = 2'd0,
        MODMUL_RUN  = 2'd1,
        MODMUL_DONE = 2'd2
    } modmul_state_t;

    localparam int DEFAULT_DATA_WIDTH = 12;

    // Width of a bit index into a data word; at least one bit so that a
    // 1-bit datapath still has a legal index register.
    function automatic int idx_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

    localparam int DEFAULT_IDX_W = idx_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/mod_add_step.sv
// Combinational modular addition: r = (x + y) mod q, valid for x, y < q.
// The sum is carried one bit wider than the operands so the compare against
// q never sees a truncated value.
module mod_add_step
    import modarith_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] x_i,
    input  logic [DATA_WIDTH-1:0] y_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic [DATA_WIDTH-1:0] r_o
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] red;

    // Add, then subtract q once if the sum reached or passed it.
    always_comb begin
        sum = {1'b0, x_i} + {1'b0, y_i};
        red = sum;
        if (sum >= {1'b0, q_i}) begin
            red = sum - {1'b0, q_i};
        end
        r_o = red[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/modmul_seq.sv
// Iterative modular multiplier: out = (a * b) mod modulant, one multiplier
// bit per cycle, MSB first (double-and-add with conditional subtraction).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// out stays stable until out_ready is seen. Inputs are sampled only on the
// accept edge, so later changes to a, b or modulant have no effect.
//
// Optional build macro MODMUL_SKIP_LZ_EN: start from b's highest set bit so
// latency is msb(b)+1 cycles (1 for b=0). Without it, latency is DATA_WIDTH.
module modmul_seq
    import modarith_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] modulant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  busy,
    output modmul_state_t         state_o
);

    localparam int IW = idx_width(DATA_WIDTH);

    modmul_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [IW-1:0]         idx_q, idx_d;

    logic [DATA_WIDTH-1:0] dbl;
    logic [DATA_WIDTH-1:0] dbl_add;
    logic [DATA_WIDTH-1:0] step;
    logic [IW-1:0]         start_idx;

`ifdef MODMUL_SKIP_LZ_EN
    // Position of the highest set bit; 0 when v is zero.
    function automatic logic [IW-1:0] msb_idx(input logic [DATA_WIDTH-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    assign start_idx = msb_idx(b);
`else
    assign start_idx = IW'(DATA_WIDTH - 1);
`endif

    // d = 2*acc mod q
    mod_add_step #(.DATA_WIDTH(DATA_WIDTH)) u_double (
        .x_i (acc_q),
        .y_i (acc_q),
        .q_i (q_q),
        .r_o (dbl)
    );

    // s = d + a mod q (used only when the current multiplier bit is set)
    mod_add_step #(.DATA_WIDTH(DATA_WIDTH)) u_add (
        .x_i (dbl),
        .y_i (a_q),
        .q_i (q_q),
        .r_o (dbl_add)
    );

    assign step = b_q[idx_q] ? dbl_add : dbl;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MODMUL_IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            out_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        out_d   = out_q;
        idx_d   = idx_q;
        unique case (state_q)
            MODMUL_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    q_d     = modulant;
                    acc_d   = '0;
                    idx_d   = start_idx;
                    state_d = MODMUL_RUN;
                end
            end
            MODMUL_RUN: begin
                acc_d = step;
                if (idx_q == '0) begin
                    out_d   = step;
                    state_d = MODMUL_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            MODMUL_DONE: begin
                if (out_ready) begin
                    state_d = MODMUL_IDLE;
                end
            end
            default: state_d = MODMUL_IDLE;
        endcase
    end

    assign in_ready  = (state_q == MODMUL_IDLE);
    assign out_valid = (state_q == MODMUL_DONE);
    assign busy      = (state_q == MODMUL_RUN) || (state_q == MODMUL_DONE);
    assign out       = out_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_modmul_seq.sv
// Directed bench for modmul_seq at DATA_WIDTH=12 with hand-computed results.
// Expected latency follows the MODMUL_SKIP_LZ_EN build setting.
module tb_modmul_seq;
    import modarith_pkg::*;

    localparam int W = 12;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  modulant;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic          busy;
    modmul_state_t state_o;

    int n_checks = 0;
    int n_fail   = 0;

    modmul_seq #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .modulant  (modulant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy),
        .state_o   (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] bv);
        int n;
`ifdef MODMUL_SKIP_LZ_EN
        n = 1;
        for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
`else
        n = W;
`endif
        return n;
    endfunction

    // Present operands, wait for the accept edge, then count edges until
    // out_valid. Optionally scramble inputs during RUN and stall the output.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] qv, input logic [W-1:0] expv,
                          input bit scramble, input int hold);
        int cnt;
        @(negedge clk);
        a = av; b = bv; modulant = qv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        if (scramble) begin
            a = 12'd4000; b = 12'd4095; modulant = 12'd5;
        end
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, " latency"}, 32'(cnt), 32'(exp_lat(bv)));
        check({tag, " out"}, 32'(out), 32'(expv));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 12'd7; b = 12'd9; modulant = 12'd11;
            @(posedge clk); #1;
            check({tag, " hold out"}, 32'(out), 32'(expv));
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " out held"}, 32'(out), 32'(expv));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; modulant = 12'd3329;
        #12;
        check("reset out", 32'(out), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset state", 32'(state_o), 32'(MODMUL_IDLE));
        @(negedge clk); rst_n = 1'b1;

        run_op("kyber",   12'd17,   12'd1175, 12'd3329, 12'd1,    1'b0, 0);
        run_op("neg1sq",  12'd3328, 12'd3328, 12'd3329, 12'd1,    1'b0, 0);
        run_op("a0",      12'd0,    12'd1234, 12'd3329, 12'd0,    1'b0, 0);
        run_op("b1",      12'd1234, 12'd1,    12'd3329, 12'd1234, 1'b0, 0);
        run_op("b0",      12'd1234, 12'd0,    12'd3329, 12'd0,    1'b0, 0);
        run_op("mix",     12'd100,  12'd200,  12'd3329, 12'd26,   1'b0, 0);
        run_op("q97",     12'd50,   12'd60,   12'd97,   12'd90,   1'b0, 0);
        run_op("qmax",    12'd4094, 12'd4094, 12'd4095, 12'd1,    1'b0, 0);
        run_op("q2",      12'd1,    12'd1,    12'd2,    12'd1,    1'b0, 0);
        run_op("stall",   12'd17,   12'd1175, 12'd3329, 12'd1,    1'b0, 5);
        run_op("scramble",12'd100,  12'd200,  12'd3329, 12'd26,   1'b1, 0);

        // Reset during RUN at iteration 6, then a fresh operation.
        @(negedge clk);
        a = 12'd3328; b = 12'd3328; modulant = 12'd3329; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset in_ready", 32'(in_ready), 32'd1);
        check("mid reset busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op("post-reset", 12'd17, 12'd1175, 12'd3329, 12'd1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
